// File: rtl/if_id_buffer.sv
// IF/ID instruction buffer: a small circular FIFO between fetch and decode.
// Fetch pushes {PC, NPC, IR} entries and decode consumes the head entry.
//
// Handshake: fetch offers an entry with if_valid_inst_in and must hold while
// buf_full is high (a push offered while full is dropped). Decode sees a valid
// head when if_id_valid_inst is high and consumes it on any edge where
// hazard_detected is low. A taken branch (ex_take_branch_out) flushes every
// buffered entry and drops any same-cycle push or pop. There is no bypass path,
// so a pushed entry reaches the outputs one cycle later at the earliest.
module if_id_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid_inst_in,
    input  logic [31:0]                if_PC_in,
    input  logic [31:0]                if_NPC_in,
    input  logic [31:0]                if_IR_in,
    input  logic                       hazard_detected,
    input  logic                       ex_take_branch_out,
    output logic [31:0]                if_id_PC,
    output logic [31:0]                if_id_NPC,
    output logic [31:0]                if_id_IR,
    output logic                       if_id_valid_inst,
    output logic                       buf_full,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry storage; contents are qualified by count, so no reset is needed.
    logic [31:0] pc_mem  [DEPTH];
    logic [31:0] npc_mem [DEPTH];
    logic [31:0] ir_mem  [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Status flags come from registered count only.
    assign if_id_valid_inst = (count_q != '0);
    assign buf_full         = (count_q == FULL_CNT);
    assign buf_count        = count_q;

    assign push = if_valid_inst_in && !buf_full && !ex_take_branch_out;
    assign pop  = if_id_valid_inst && !hazard_detected && !ex_take_branch_out;

    // Head entry is presented directly from storage; empty shows a NOP bubble.
    always_comb begin
        if_id_PC  = 32'h0;
        if_id_NPC = 32'h0;
        if_id_IR  = NOP_INST;
        if (if_id_valid_inst) begin
            if_id_PC  = pc_mem[head_q];
            if_id_NPC = npc_mem[head_q];
            if_id_IR  = ir_mem[head_q];
        end
    end

    // Next-state for pointers and count; a flush overrides push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (ex_take_branch_out) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at tail; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail_q]  <= if_PC_in;
            npc_mem[tail_q] <= if_NPC_in;
            ir_mem[tail_q]  <= if_IR_in;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=4): bypass-free streaming, stall
// fill, drain, drop-while-full, branch flush, wrap-around stream, mid-stream
// reset.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        if_valid_inst_in;
    logic [31:0] if_PC_in;
    logic [31:0] if_NPC_in;
    logic [31:0] if_IR_in;
    logic        hazard_detected;
    logic        ex_take_branch_out;
    logic [31:0] if_id_PC;
    logic [31:0] if_id_NPC;
    logic [31:0] if_id_IR;
    logic        if_id_valid_inst;
    logic        buf_full;
    logic [2:0]  buf_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    if_id_buffer #(.DEPTH(4), .NOP_INST(NOP)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_valid_inst_in   (if_valid_inst_in),
        .if_PC_in           (if_PC_in),
        .if_NPC_in          (if_NPC_in),
        .if_IR_in           (if_IR_in),
        .hazard_detected    (hazard_detected),
        .ex_take_branch_out (ex_take_branch_out),
        .if_id_PC           (if_id_PC),
        .if_id_NPC          (if_id_NPC),
        .if_id_IR           (if_id_IR),
        .if_id_valid_inst   (if_id_valid_inst),
        .buf_full           (buf_full),
        .buf_count          (buf_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer (or withdraw) a fetch entry for the next edge.
    task automatic drive(input logic v, input logic [31:0] pc);
        if_valid_inst_in = v;
        if_PC_in         = pc;
        if_NPC_in        = pc + 32'd4;
        if_IR_in         = ir_of(pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".count"}, 32'(buf_count), 32'd0);
        check({tag, ".valid"}, 32'(if_id_valid_inst), 32'd0);
        check({tag, ".full"},  32'(buf_full), 32'd0);
        check({tag, ".ir"},    if_id_IR, NOP);
        check({tag, ".pc"},    if_id_PC, 32'd0);
        check({tag, ".npc"},   if_id_NPC, 32'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input int cnt);
        check({tag, ".pc"},    if_id_PC, pc);
        check({tag, ".npc"},   if_id_NPC, pc + 32'd4);
        check({tag, ".ir"},    if_id_IR, ir_of(pc));
        check({tag, ".valid"}, 32'(if_id_valid_inst), 32'd1);
        check({tag, ".count"}, 32'(buf_count), 32'(cnt));
        check({tag, ".full"},  32'(buf_full), (cnt == 4) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 1'b0;
        ex_take_branch_out = 1'b0;
        drive(1'b0, 32'd0);
        step();
        step();
        rst = 1'b0;
        check_empty("reset");

        // Streaming with no stall: each entry shows one cycle after push.
        drive(1'b1, 32'd0); step(); check_head("stream0", 32'd0, 1);
        drive(1'b1, 32'd4); step(); check_head("stream4", 32'd4, 1);
        drive(1'b1, 32'd8); step(); check_head("stream8", 32'd8, 1);
        drive(1'b0, 32'd0); step(); check_empty("stream_end");

        // Stall fill: four pushes fill, fifth is dropped, head stays PC 0.
        hazard_detected = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 4));
            step();
            check_head("fill", 32'd0, (i < 4) ? i + 1 : 4);
        end

        // Drain in order once the stall releases.
        hazard_detected = 1'b0;
        drive(1'b0, 32'd0);
        step(); check_head("drain4", 32'd4, 3);
        step(); check_head("drain8", 32'd8, 2);
        step(); check_head("drain12", 32'd12, 1);
        step(); check_empty("drained");

        // Push offered while full is dropped even though a pop happens.
        hazard_detected = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(i * 4));
            step();
        end
        check_head("refill", 32'h40, 4);
        hazard_detected = 1'b0;
        drive(1'b1, 32'h50);
        step(); check_head("popfull", 32'h44, 3);
        drive(1'b0, 32'd0);
        step(); check_head("popfull48", 32'h48, 2);
        step(); check_head("popfull4c", 32'h4C, 1);
        step(); check_empty("popfull_end");

        // Branch flush with three buffered and a push on the same cycle.
        hazard_detected = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(i * 4));
            step();
        end
        check_head("preflush", 32'h20, 3);
        hazard_detected = 1'b0;
        ex_take_branch_out = 1'b1;
        drive(1'b1, 32'h2C);
        step();
        ex_take_branch_out = 1'b0;
        drive(1'b0, 32'd0);
        check_empty("flush");

        // Steady stream at count 2 across pointer wrap, scoreboard order.
        hazard_detected = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4));
            exp_q.push_back(32'h100 + 32'(i * 4));
            step();
        end
        hazard_detected = 1'b0;
        for (int i = 2; i < 12; i++) begin
            check_head("wrap", exp_q[0], 2);
            drive(1'b1, 32'h100 + 32'(i * 4));
            exp_q.push_back(32'h100 + 32'(i * 4));
            void'(exp_q.pop_front());
            step();
        end
        drive(1'b0, 32'd0);
        while (exp_q.size() > 0) begin
            check_head("wrap_drain", exp_q[0], exp_q.size());
            void'(exp_q.pop_front());
            step();
        end
        check_empty("wrap_end");

        // Reset mid-stream with two buffered and a stall asserted.
        hazard_detected = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4));
            step();
        end
        check_head("prerst", 32'h200, 2);
        rst = 1'b1;
        drive(1'b1, 32'h208);
        step();
        rst = 1'b0;
        hazard_detected = 1'b0;
        drive(1'b0, 32'd0);
        check_empty("midrst");
        step();
        check_empty("midrst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of instruction entries (power of two, at least 2).
REQ-002 The block SHALL have parameter NOP_INST, default 32'h00000013, instruction presented when the buffer is empty.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port if_valid_inst_in  input  1  fetch stage presents a valid instruction this cycle.
REQ-006 The block SHALL have port if_PC_in  input  32  PC of the presented instruction.
REQ-007 The block SHALL have port if_NPC_in  input  32  PC+4 of the presented instruction.
REQ-008 The block SHALL have port if_IR_in  input  32  presented instruction word.
REQ-009 The block SHALL have port hazard_detected  input  1  decode stall; head entry must not be consumed.
REQ-010 The block SHALL have port ex_take_branch_out  input  1  taken branch in EX; flush all buffered entries.
REQ-011 The block SHALL have port if_id_PC  output  32  PC of head entry.
REQ-012 The block SHALL have port if_id_NPC  output  32  NPC of head entry.
REQ-013 The block SHALL have port if_id_IR  output  32  instruction of head entry, NOP_INST when empty.
REQ-014 The block SHALL have port if_id_valid_inst  output  1  head entry is valid.
REQ-015 The block SHALL have port buf_full  output  1  count equals DEPTH; fetch must hold.
REQ-016 The block SHALL have port buf_count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 The block SHALL store entries {PC, NPC, IR} in a circular array indexed by head and tail pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0.
REQ-018 Push SHALL be defined as if_valid_inst_in && !buf_full && !ex_take_branch_out; on push, the entry is written at tail and tail increments.
REQ-019 Pop SHALL be defined as if_id_valid_inst && !hazard_detected && !ex_take_branch_out; on pop, head increments.
REQ-020 buf_count SHALL update as count + push - pop each cycle; a simultaneous push and pop leaves it unchanged.
REQ-021 A push while buf_full is high SHALL be dropped with no state change; no bypass is allowed when full, even if a pop occurs that cycle.
REQ-022 The block SHALL have no bypass path: an instruction pushed in cycle N appears at the outputs no earlier than cycle N+1, with latency exactly 1 cycle when the buffer is empty.
REQ-023 if_id_valid_inst SHALL equal (buf_count != 0), and buf_full SHALL equal (buf_count == DEPTH); both are decoded from registered state only.
REQ-024 When buf_count is 0, if_id_IR SHALL be NOP_INST and if_id_PC and if_id_NPC SHALL be 0.
REQ-025 When buf_count is nonzero, the outputs SHALL reflect the head entry combinationally from stored state.
REQ-026 When ex_take_branch_out is high, on the next edge head, tail and buf_count SHALL reset to 0; this overrides any push, pop or stall in the same cycle.
REQ-027 While hazard_detected is high, the head entry SHALL remain stable on the outputs, and pushes SHALL continue until the buffer is full.
REQ-028 Storage array contents SHALL NOT require reset; only pointers and count are reset.
REQ-029 Entry order SHALL be strict FIFO; no entry may be duplicated or skipped across pointer wrap-around.

Reset
REQ-030 When rst is high at a clock edge, head, tail and buf_count SHALL be set to 0; after that edge, if_id_valid_inst=0, buf_full=0, if_id_IR=NOP_INST, if_id_PC=0 and if_id_NPC=0.
REQ-031 rst SHALL take priority over ex_take_branch_out, push and pop, and an operation in progress when reset is asserted SHALL be discarded.

Verification
REQ-032 Push PC=0,4,8 on consecutive cycles with no stall -> outputs show PC 0,4,8 each one cycle after push, buf_count stays at most 1, and IR is NOP_INST the cycle after the stream ends.
REQ-033 Hold hazard_detected=1 and push 5 instructions with DEPTH=4 -> buf_full=1 after the 4th push, the 5th is dropped, and the head stays at PC=0 throughout.
REQ-034 Release the stall with buf_count=4 and no pushes -> PCs 0,4,8,12 drain in order over 4 cycles, then if_id_valid_inst=0.
REQ-035 Assert ex_take_branch_out with buf_count=3 and a push on the same cycle -> next cycle buf_count=0, if_id_valid_inst=0 and IR=NOP_INST.
REQ-036 Run a steady push and pop stream for 10 cycles with count held at 2 -> pointers wrap past 3 and PCs appear in order with no loss or duplication.
REQ-037 Assert rst mid-stream with buf_count=2 and hazard_detected=1 -> next cycle buf_count=0 and all outputs hold their reset values.
